as_gpio_port: RTL

- Memory-mapped GPIO peripheral that drives the `gpio_io` pins and the `cs_o` strobe sampled by the system testbenches.
- It is the transmitting end of that interface. A CPU store to the data register puts the value on the pins and pulses `cs_o` while the data is stable.
- Sits between the core's peripheral load/store bus and the top-level pads in `as_top_mem`.
- Also provides per-pin direction control and a synchronized input read-back.

---
 rtl/as_gpio_port.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/as_gpio_port.sv
// as_gpio_port -- memory-mapped GPIO peripheral, transmitting end of the
// gpio_io / cs_o observer interface.
//
// A store to DATA_OUT puts the value on the pins and raises cs_o for
// CS_CYCLES cycles while the pins are stable, followed by one low GAP cycle
// so back-to-back strobes are distinct edges. Per-pin direction control and a
// synchronized read-back of the pins are also provided.
//
// Ports:
//   clk_i    in     1         system clock, rising edge
//   rst_i    in     1         asynchronous active-low reset
//   we_i     in     1         write request, held until ack_o
//   re_i     in     1         read request, held until ack_o
//   addr_i   in     2         0 DATA_OUT, 1 DIR, 2 DATA_IN (ro), 3 STATUS (ro)
//   wdata_i  in     DATA_W    write data (bits above NR_GPIOS ignored)
//   rdata_o  out    DATA_W    read data, valid while ack_o = 1
//   ack_o    out    1         one-cycle completion pulse
//   gpio_io  inout  NR_GPIOS  tristate pins
//   cs_o     out    1         data-valid strobe
module as_gpio_port #(
    parameter int unsigned NR_GPIOS    = 8,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned CS_CYCLES   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [1:0]          addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ack_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    localparam int unsigned      CNT_W    = (CS_CYCLES > 1) ? $clog2(CS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CS_CYCLES - 1);

    localparam logic [1:0] A_DATA_OUT = 2'd0;
    localparam logic [1:0] A_DIR      = 2'd1;
    localparam logic [1:0] A_DATA_IN  = 2'd2;

    if (CS_CYCLES < 1) begin : g_bad_cs_cycles
        $error("as_gpio_port: CS_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("as_gpio_port: SYNC_STAGES must be >= 2");
    end
    if (DATA_W < 32 || DATA_W <= NR_GPIOS) begin : g_bad_data_w
        $error("as_gpio_port: DATA_W must be >= 32 and wider than NR_GPIOS");
    end

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [15:0]         strobe_cnt;
    logic [NR_GPIOS-1:0] data_out;
    logic [NR_GPIOS-1:0] dir;
    logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0]   rd_mux;
    logic                unused_wdata_hi;

    assign unused_wdata_hi = ^wdata_i[DATA_W-1:NR_GPIOS];

    // Pins are driven only from registers.
    for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pin
        assign gpio_io[i] = dir[i] ? data_out[i] : 1'bz;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_io;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            A_DATA_OUT: rd_mux[NR_GPIOS-1:0] = data_out;
            A_DIR:      rd_mux[NR_GPIOS-1:0] = dir;
            A_DATA_IN:  rd_mux[NR_GPIOS-1:0] = sync_q[SYNC_STAGES-1];
            default: begin
                rd_mux[0]     = (state != ST_IDLE);
                rd_mux[31:16] = strobe_cnt;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            strobe_cnt <= '0;
            data_out   <= '0;
            dir        <= '0;
            cs_o       <= 1'b0;
            ack_o      <= 1'b0;
            rdata_o    <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Writes are only accepted here, so data_out and dir
                    // cannot change while cs_o is high.
                    if (we_i) begin
                        ack_o <= 1'b1;
                        case (addr_i)
                            A_DATA_OUT: begin
                                data_out   <= wdata_i[NR_GPIOS-1:0];
                                cs_o       <= 1'b1;
                                cnt        <= CNT_INIT;
                                strobe_cnt <= strobe_cnt + 16'd1;
                                state      <= ST_STROBE;
                            end
                            A_DIR:   dir <= wdata_i[NR_GPIOS-1:0];
                            default: ;
                        endcase
                    end
                end
                ST_STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cs_o  <= 1'b0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // A pending write (accepted or stalled) suppresses the read.
            if (re_i && !we_i) begin
                ack_o   <= 1'b1;
                rdata_o <= rd_mux;
            end
        end
    end

endmodule
